mult_div_seq: RTL and testbench

MULT_DIV_SEQ -- requirements
Module: mult_div_seq

---
 rtl/mips_ctrl_pkg.sv | 23 ++
 rtl/mult_div_datapath.sv | 97 +++++++++
 rtl/mult_div_seq.sv | 110 +++++++++++
 tb/tb_mult_div_seq.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the sequential multiply/divide unit:
// state encoding, operation codes and iteration count.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        FIX  = 3'd2,
        DONE = 3'd3,
        DZ   = 3'd4
    } md_state_e;

    localparam logic        OP_MULT = 1'b0;
    localparam logic        OP_DIV  = 1'b1;
    localparam int unsigned MD_ITER = 32;
    localparam int unsigned CNT_W   = $clog2(MD_ITER);

    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? -v : v;
    endfunction

endpackage

// File: rtl/mult_div_datapath.sv
// Magnitude capture, one shift-add / restoring shift-subtract step per cycle,
// and the sign fix that loads HI/LO.
module mult_div_datapath
    import mips_ctrl_pkg::*;
(
    input  logic        clck,
    input  logic        reset_n,
    input  logic        load,
    input  logic        step,
    input  logic        commit,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic        op_q;
    logic        sign_a_q;
    logic        sign_b_q;
    logic [31:0] mag_a_q;
    logic [31:0] mag_b_q;
    logic [63:0] acc_q;
    logic [63:0] acc_d;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] hi_d;
    logic [31:0] lo_d;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_sh;
    logic        rem_geq;
    logic [31:0] rem_sub;
    logic [63:0] div_next;
    logic [63:0] prod_fix;

    // acc holds {partial product, multiplier} for mult and {remainder, quotient} for div.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};

        rem_sh   = acc_q[63:31];
        rem_geq  = rem_sh >= {1'b0, mag_b_q};
        rem_sub  = rem_sh[31:0] - mag_b_q;
        div_next = rem_geq ? {rem_sub, acc_q[30:0], 1'b1}
                           : {rem_sh[31:0], acc_q[30:0], 1'b0};

        acc_d = acc_q;
        if (load) begin
            acc_d = {32'd0, (op == OP_DIV) ? abs32(a) : abs32(b)};
        end else if (step) begin
            acc_d = (op_q == OP_DIV) ? div_next : mul_next;
        end

        prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (commit) begin
            if (op_q == OP_MULT) begin
                hi_d = prod_fix[63:32];
                lo_d = prod_fix[31:0];
            end else begin
                hi_d = sign_a_q ? -acc_q[63:32] : acc_q[63:32];
                lo_d = (sign_a_q ^ sign_b_q) ? -acc_q[31:0] : acc_q[31:0];
            end
        end
    end

    always_ff @(negedge clck or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= OP_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            if (load) begin
                op_q     <= op;
                sign_a_q <= a[31];
                sign_b_q <= b[31];
                mag_a_q  <= abs32(a);
                mag_b_q  <= abs32(b);
            end
            acc_q <= acc_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/mult_div_seq.sv
// Sequential signed multiply/divide unit: control FSM and iteration counter;
// all arithmetic lives in mult_div_datapath.
module mult_div_seq
    import mips_ctrl_pkg::*;
(
    input  logic        clck,
    input  logic        reset_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        hilo_write,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_ITER - 1);

    md_state_e        state_q;
    md_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             load;
    logic             step;
    logic             commit;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load       = 1'b0;
        step       = 1'b0;
        commit     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        div_zero   = 1'b0;
        hilo_write = 1'b0;
        case (state_q)
            IDLE: begin
                // abort outranks start so a flushed instruction never begins
                if (start && !abort) begin
                    if (op == OP_DIV && b == '0) begin
                        state_d = DZ;
                    end else begin
                        state_d = RUN;
                        load    = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_d = FIX;
                end
            end
            FIX: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    commit  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                hilo_write = 1'b1;
                state_d    = IDLE;
            end
            DZ: begin
                div_zero = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clck or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    mult_div_datapath u_datapath (
        .clck    (clck),
        .reset_n (reset_n),
        .load    (load),
        .step    (step),
        .commit  (commit),
        .op      (op),
        .a       (a),
        .b       (b),
        .hi      (hi),
        .lo      (lo)
    );

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq: expected HI/LO queued at start, checked at done.
module tb_mult_div_seq;

    logic        clck = 1'b1;
    logic        reset_n;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        abort;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        hilo_write;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    logic [63:0] exp_q[$];

    always #5 clck = ~clck;

    mult_div_seq dut (
        .clck       (clck),
        .reset_n    (reset_n),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hilo_write (hilo_write),
        .hi         (hi),
        .lo         (lo)
    );

    // Reference: 64-bit signed arithmetic, {hi, lo}
    function automatic logic [63:0] model(input logic opx, input logic [31:0] ax, input logic [31:0] bx);
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        sa = longint'($signed(ax));
        sb = longint'($signed(bx));
        if (!opx) begin
            p = sa * sb;
            return p;
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic do_op(input logic opx, input logic [31:0] ax, input logic [31:0] bx, input string tag);
        logic [63:0] prev;
        logic [63:0] expv;
        int n;
        prev = {hi, lo};
        exp_q.push_back(model(opx, ax, bx));
        @(posedge clck);
        start = 1'b1; op = opx; a = ax; b = bx;
        @(negedge clck); #1;
        start = 1'b0;
        n = 1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_start: got %b expected 1", tag, busy);
        end
        while (done !== 1'b1 && n < 40) begin
            @(negedge clck); #1;
            n++;
            if (n == 33) begin
                n_cmp++;
                if ({hi, lo} !== prev) begin
                    n_fail++;
                    $display("FAIL %s early_write: got %h expected %h", tag, {hi, lo}, prev);
                end
            end
        end
        expv = exp_q.pop_front();
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_timeout: got done=%b expected 1 within 40 edges", tag, done);
        end else begin
            if (n != 34) begin
                n_fail++;
                $display("FAIL %s latency: got %0d expected 34", tag, n);
            end
            n_cmp++;
            if (hilo_write !== 1'b1) begin
                n_fail++;
                $display("FAIL %s hilo_write: got %b expected 1", tag, hilo_write);
            end
            n_cmp++;
            if (hi !== expv[63:32]) begin
                n_fail++;
                $display("FAIL %s hi: got %h expected %h", tag, hi, expv[63:32]);
            end
            n_cmp++;
            if (lo !== expv[31:0]) begin
                n_fail++;
                $display("FAIL %s lo: got %h expected %h", tag, lo, expv[31:0]);
            end
        end
        @(negedge clck); #1;
        n_cmp++;
        if ({done, busy, hilo_write} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s end_idle: got done,busy,hw=%b expected 000", tag, {done, busy, hilo_write});
        end
    endtask

    task automatic start_and_advance(input logic opx, input logic [31:0] ax, input logic [31:0] bx, input int upto);
        @(posedge clck);
        start = 1'b1; op = opx; a = ax; b = bx;
        @(negedge clck); #1;
        start = 1'b0;
        repeat (upto - 1) begin
            @(negedge clck); #1;
        end
    endtask

    task automatic watch_no_done(input int cycles, input string tag);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clck); #1;
            if (done === 1'b1 || hilo_write === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_fail++;
            $display("FAIL %s no_done: got done/hilo_write pulse expected none", tag);
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({busy, done, div_zero, hilo_write} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, div_zero, hilo_write});
        end
        n_cmp++;
        if ({hi, lo} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
        end
        @(posedge clck);
        reset_n = 1'b1;
    endtask

    task automatic test_mult();
        do_op(1'b0, 32'd7, 32'hFFFF_FFFD, "mult_7_m3");
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, "mult_min_min");
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1_m1");
        do_op(1'b0, 32'd0, 32'h1234_5678, "mult_zero");
        do_op(1'b0, 32'h7FFF_FFFF, 32'h8000_0000, "mult_max_min");
        for (int i = 0; i < 3; i++) do_op(1'b0, $urandom, $urandom, "mult_rand");
    endtask

    task automatic test_div();
        logic [31:0] rb;
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
        do_op(1'b1, 32'd3, 32'd10, "div_small");
        do_op(1'b1, 32'h8000_0000, 32'h8000_0000, "div_min_min");
        for (int i = 0; i < 3; i++) begin
            rb = $urandom;
            if (rb == 32'd0) rb = 32'd1;
            do_op(1'b1, $urandom, rb, "div_rand");
        end
    endtask

    task automatic test_div_zero();
        logic [63:0] prev;
        prev = {hi, lo};
        @(posedge clck);
        start = 1'b1; op = 1'b1; a = 32'd5; b = 32'd0;
        @(negedge clck); #1;
        start = 1'b0;
        n_cmp++;
        if ({div_zero, busy, done, hilo_write} !== 4'b1000) begin
            n_fail++;
            $display("FAIL dz_pulse: got dz,busy,done,hw=%b expected 1000", {div_zero, busy, done, hilo_write});
        end
        @(negedge clck); #1;
        n_cmp++;
        if ({div_zero, busy, done, hilo_write} !== 4'b0000) begin
            n_fail++;
            $display("FAIL dz_end: got dz,busy,done,hw=%b expected 0000", {div_zero, busy, done, hilo_write});
        end
        n_cmp++;
        if ({hi, lo} !== prev) begin
            n_fail++;
            $display("FAIL dz_hilo: got %h expected %h", {hi, lo}, prev);
        end
    endtask

    task automatic test_restart_ignored();
        logic [63:0] expv;
        int n;
        exp_q.push_back(model(1'b0, 32'hDEAD_BEEF, 32'h0123_4567));
        start_and_advance(1'b0, 32'hDEAD_BEEF, 32'h0123_4567, 11);
        @(posedge clck);
        start = 1'b1; op = 1'b1; a = 32'd99; b = 32'd4;
        @(negedge clck); #1;
        start = 1'b0;
        n = 12;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clck); #1;
            n++;
        end
        expv = exp_q.pop_front();
        n_cmp++;
        if (done !== 1'b1 || n != 34) begin
            n_fail++;
            $display("FAIL restart_latency: got done=%b at edge %0d expected done at 34", done, n);
        end
        n_cmp++;
        if ({hi, lo} !== expv) begin
            n_fail++;
            $display("FAIL restart_result: got %h expected %h", {hi, lo}, expv);
        end
        watch_no_done(40, "restart_no_second");
    endtask

    task automatic test_reset_mid();
        start_and_advance(1'b0, 32'd123, 32'd456, 16);
        @(posedge clck);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, div_zero, hilo_write} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_ctrl: got %b expected 0000", {busy, done, div_zero, hilo_write});
        end
        n_cmp++;
        if ({hi, lo} !== 64'd0) begin
            n_fail++;
            $display("FAIL midreset_hilo: got %h expected 0", {hi, lo});
        end
        @(posedge clck);
        reset_n = 1'b1;
        watch_no_done(40, "midreset");
    endtask

    task automatic test_abort();
        logic [63:0] prev;
        do_op(1'b1, 32'd100, 32'd7, "abort_pre");
        prev = {hi, lo};

        start_and_advance(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 20);
        @(posedge clck); abort = 1'b1;
        @(negedge clck); #1; abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_run_idle: got busy=%b expected 0", busy);
        end
        watch_no_done(40, "abort_run");
        n_cmp++;
        if ({hi, lo} !== prev) begin
            n_fail++;
            $display("FAIL abort_run_hilo: got %h expected %h", {hi, lo}, prev);
        end

        start_and_advance(1'b1, 32'd1000, 32'd3, 33);
        @(posedge clck); abort = 1'b1;
        @(negedge clck); #1; abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_fix_idle: got busy=%b expected 0", busy);
        end
        watch_no_done(40, "abort_fix");
        n_cmp++;
        if ({hi, lo} !== prev) begin
            n_fail++;
            $display("FAIL abort_fix_hilo: got %h expected %h", {hi, lo}, prev);
        end

        @(posedge clck);
        abort = 1'b1; start = 1'b1; op = 1'b0; a = 32'd5; b = 32'd6;
        @(negedge clck); #1;
        abort = 1'b0; start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_start_idle: got busy=%b expected 0", busy);
        end
        watch_no_done(40, "abort_start");

        start_and_advance(1'b0, 32'hFFFF_FFFB, 32'd9, 34);
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_done_pulse: got done=%b expected 1", done);
        end
        @(posedge clck); abort = 1'b1;
        @(negedge clck); #1; abort = 1'b0;
        n_cmp++;
        if ({hi, lo} !== model(1'b0, 32'hFFFF_FFFB, 32'd9)) begin
            n_fail++;
            $display("FAIL abort_done_hilo: got %h expected %h", {hi, lo}, model(1'b0, 32'hFFFF_FFFB, 32'd9));
        end
    endtask

    task automatic test_back_to_back();
        do_op(1'b0, 32'd12345, 32'hFFFF_0000, "b2b_0");
        do_op(1'b1, 32'hF000_0001, 32'd13, "b2b_1");
        do_op(1'b0, $urandom, $urandom, "b2b_2");
        do_op(1'b1, 32'd65536, 32'hFFFF_FFF0, "b2b_3");
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 1'b0;
        a       = '0;
        b       = '0;
        abort   = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_restart_ignored();
        test_reset_mid();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
